// File: rtl/rv_boot_ctrl_pkg.sv
// Shared definitions for the rv_core boot/run sequencer: FSM state encoding,
// fail codes and a state classification helper.
package rv_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } state_e;

  localparam logic [1:0] FAIL_NONE     = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAIL_OVERFLOW = 2'b10;
  localparam logic [1:0] FAIL_CHECKSUM = 2'b11;

  // Resting states are the only ones that accept a new start.
  function automatic logic is_rest(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/rv_boot_ctrl_timer.sv
// Saturating cycle counter with synchronous clear/enable and a flag raised
// while the count sits one below a non-zero limit.
module rv_boot_ctrl_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_d, count_q;

  // Next count: clear wins over enable, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hit   = (limit != '0) && (count_q == (limit - W'(1)));

endmodule

// File: rtl/rv_boot_ctrl.sv
// Boot/run sequencer for rv_core: streams an image into instruction BRAM, holds
// the core in reset, then supervises the run. Option macro: RV_BOOT_CHECKSUM_EN.
module rv_boot_ctrl
  import rv_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 4,
  parameter int BUDGET_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                ld_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                core_rstn,
  input  logic                core_halt,
  input  logic [BUDGET_W-1:0] run_budget,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [1:0]          fail_code,
  output logic [BUDGET_W-1:0] cycles
);

  localparam logic [ADDR_W-1:0]   ADDR_LAST = '1;
  localparam logic [BUDGET_W-1:0] HOLD_LIM  = BUDGET_W'(RST_HOLD);

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [BUDGET_W-1:0] budget_d, budget_q;
  logic [1:0]          fail_code_d, fail_code_q;
  logic                mem_we_d, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
  logic                ld_ready_d, ld_ready_q;
  logic                core_rstn_d, core_rstn_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                fail_d, fail_q;
`ifdef RV_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_d, sum_q;
`endif

  logic                beat;
  logic                tmr_clr, tmr_en, tmr_hit;
  logic [BUDGET_W-1:0] tmr_limit, tmr_count;

  assign beat = ld_valid && ld_ready_q;

  // One timer serves both phases: it measures the reset hold, then restarts
  // from zero on entry to RUN so its count is the run cycle count.
  assign tmr_clr   = (start && is_rest(state_q)) || ((state_q == ST_HOLD) && tmr_hit);
  assign tmr_en    = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign tmr_limit = (state_q == ST_HOLD) ? HOLD_LIM : budget_q;

  rv_boot_ctrl_timer #(.W(BUDGET_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .count (tmr_count),
    .hit   (tmr_hit)
  );

  // Sequencer next-state, load datapath and registered output values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    budget_d    = budget_q;
    fail_code_d = fail_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef RV_BOOT_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d     = ST_LOAD;
          addr_d      = '0;
          fail_code_d = FAIL_NONE;
`ifdef RV_BOOT_CHECKSUM_EN
          sum_d       = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (beat) begin
`ifdef RV_BOOT_CHECKSUM_EN
          // The last beat is a trailer carrying the expected sum, never stored.
          if (ld_last) begin
            if (ld_data == sum_q) begin
              state_d = ST_HOLD;
            end else begin
              state_d     = ST_FAIL;
              fail_code_d = FAIL_CHECKSUM;
            end
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = ld_data;
            addr_d      = addr_q + ADDR_W'(1);
            sum_d       = sum_q + ld_data;
            if (addr_q == ADDR_LAST) begin
              state_d     = ST_FAIL;
              fail_code_d = FAIL_OVERFLOW;
            end else begin
              state_d = state_q;
            end
          end
`else
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = ld_data;
          addr_d      = addr_q + ADDR_W'(1);
          if (ld_last) begin
            state_d = ST_HOLD;
          end else if (addr_q == ADDR_LAST) begin
            state_d     = ST_FAIL;
            fail_code_d = FAIL_OVERFLOW;
          end else begin
            state_d = state_q;
          end
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (tmr_hit) begin
          state_d  = ST_RUN;
          budget_d = run_budget;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (core_halt) begin
          state_d = ST_DONE;
        end else if (tmr_hit) begin
          state_d     = ST_FAIL;
          fail_code_d = FAIL_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ld_ready_d  = (state_d == ST_LOAD);
    core_rstn_d = (state_d == ST_RUN);
    busy_d      = !is_rest(state_d);
    done_d      = (state_d == ST_DONE);
    fail_d      = (state_d == ST_FAIL);
  end

  // State and output registers; reset drops core_rstn without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      budget_q    <= '0;
      fail_code_q <= FAIL_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_ready_q  <= 1'b0;
      core_rstn_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
`ifdef RV_BOOT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      budget_q    <= budget_d;
      fail_code_q <= fail_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_ready_q  <= ld_ready_d;
      core_rstn_q <= core_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
`ifdef RV_BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign ld_ready  = ld_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rstn = core_rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  // Hold-phase counts are internal; only run cycles are reported.
  assign cycles    = (state_q == ST_HOLD) ? '0 : tmr_count;

endmodule

// File: tb/tb_rv_boot_ctrl.sv
// Self-checking bench for rv_boot_ctrl: directed scenarios plus randomized
// images, budgets and halt points checked against a behavioural model.
module tb_rv_boot_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int HOLD  = 4;
  localparam int BW    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef RV_BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, ld_valid, ld_last, core_halt;
  logic [DW-1:0] ld_data;
  logic [BW-1:0] run_budget;
  logic          ld_ready, mem_we, core_rstn, busy, done, fail;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    fail_code;
  logic [BW-1:0] cycles;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW+DW-1:0] wr_log[$];
  logic [DW-1:0]    img[$];
  bit               img_last;

  rv_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(HOLD), .BUDGET_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rstn(core_rstn), .core_halt(core_halt),
    .run_budget(run_budget), .busy(busy), .done(done), .fail(fail),
    .fail_code(fail_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge, logging BRAM writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
  endtask

  task automatic build_image(input int n_pay, input bit rnd, input bit good_trailer);
    logic [DW-1:0] s;
    s = '0;
    img.delete();
    for (int i = 0; i < n_pay; i++) begin
      img.push_back(rnd ? DW'($urandom) : 32'h0000_0013);
      s = s + img[i];
    end
    if (CK) img.push_back(good_trailer ? s : s + 32'd1);
    img_last = 1'b1;
  endtask

  // Load the current image, then follow HOLD/RUN, comparing against the model.
  task automatic run_image(input logic [BW-1:0] budget, input int halt_at, input bit poke);
    int n, acc, hold_lo, run_cyc, n_wr, rel, guard;
    bit ok, ck_bad, exp_done;
    logic [DW-1:0] s;
    logic [1:0] exp_code;
    int exp_cyc;
    logic [AW-1:0] a;
    n = img.size();
    // Model: the image fits iff it is terminated and needs no more than DEPTH beats.
    ok = img_last && (n <= DEPTH);
    s = '0;
    for (int i = 0; i < n - 1; i++) s = s + img[i];
    ck_bad = CK && ok && (img[n-1] != s);
    n_wr = ok ? (CK ? n - 1 : n) : DEPTH;
    exp_done = 1'b0; exp_cyc = 0; exp_code = 2'b00;
    if (!ok) exp_code = 2'b10;
    else if (ck_bad) exp_code = 2'b11;
    else if (budget != '0 && (halt_at == 0 || halt_at > int'(budget))) begin
      exp_code = 2'b01; exp_cyc = int'(budget);
    end else begin
      exp_done = 1'b1; exp_cyc = halt_at;
    end

    run_budget = budget;
    wr_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ready", ld_ready, 1'b1);
    chk("start_flags", {done, fail, fail_code, cycles}, '0);

    acc = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      if (!ld_ready) break;
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = img_last && (i == n - 1);
      tick();
      acc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("accepted", acc, ok ? n : DEPTH);

    if (ok && !ck_bad) begin
      hold_lo = 0;
      guard = 0;
      while (!core_rstn && guard < 50) begin
        hold_lo++; guard++;
        tick();
      end
      chk("hold_len", hold_lo, HOLD);
      run_cyc = 0;
      guard = 0;
      while (core_rstn && guard < 3000) begin
        run_cyc++; guard++;
        core_halt = (halt_at != 0) && (run_cyc >= halt_at);
        if (poke && run_cyc == 2) begin
          run_budget = BW'($urandom_range(1, 5));
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
      start = 1'b0;
      core_halt = 1'b0;
      chk("run_len", run_cyc, exp_cyc);
    end else begin
      rel = 0;
      for (int k = 0; k < HOLD + 2; k++) begin
        if (core_rstn) rel++;
        tick();
      end
      chk("no_release", rel, 0);
    end
    chk("end_status", {busy, core_rstn, done, fail, fail_code},
        {1'b0, 1'b0, exp_done, !exp_done, exp_code});
    chk("end_cycles", cycles, BW'(exp_cyc));
    chk("wr_count", wr_log.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_log.size(); i++) begin
      a = AW'(i);
      chk("wr_entry", wr_log[i], {a, img[i]});
    end
  endtask

  initial begin
    int n_pay;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; core_halt = 1'b0;
    ld_data = '0; run_budget = '0;
    // T1: reset values and quiet idle.
    tick(); tick();
    chk("rst_vals", {ld_ready, mem_we, mem_addr, mem_wdata, core_rstn, busy, done, fail,
                     fail_code, cycles}, '0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_quiet", {busy, ld_ready, core_rstn, done, fail}, '0);

    // T2: nop image, unlimited budget, halt on run cycle 20.
    build_image(CK ? 7 : 8, 1'b0, 1'b1);
    run_image(16'd0, 20, 1'b1);
    // T3: budget 100, no halt -> timeout.
    run_image(16'd100, 0, 1'b0);
    // T4: 9 words without last -> overflow after DEPTH writes.
    img.delete();
    for (int i = 0; i < DEPTH + 1; i++) img.push_back(DW'(i + 32'h100));
    img_last = 1'b0;
    run_image(16'd0, 5, 1'b0);
    // T5: 1,2,3 with trailer 6 then 7.
    img.delete();
    img.push_back(32'd1); img.push_back(32'd2); img.push_back(32'd3); img.push_back(32'd6);
    img_last = 1'b1;
    run_image(16'd0, 3, 1'b0);
    img[3] = 32'd7;
    run_image(16'd50, 3, 1'b0);
    // Boundaries: halt and timeout in the same cycle, budget of one, halt at once.
    build_image(3, 1'b1, 1'b1);
    run_image(16'd30, 30, 1'b0);
    run_image(16'd1, 0, 1'b0);
    run_image(16'd0, 1, 1'b0);
    run_image(16'd10, 0, 1'b0);

    // T6: reset mid-load after 3 beats, then a fresh load from address 0.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = DW'(32'hA0 + i); tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst", {ld_ready, busy, core_rstn, mem_we, mem_addr, fail, fail_code}, '0);
    tick();
    rst = 1'b0;
    tick();
    build_image(4, 1'b1, 1'b1);
    run_image(16'd0, 7, 1'b0);

    // Randomized images, budgets and halt points.
    for (int r = 0; r < 14; r++) begin
      n_pay = CK ? $urandom_range(0, DEPTH - 1) : $urandom_range(1, DEPTH);
      build_image(n_pay, 1'b1, $urandom_range(0, 3) != 0);
      run_image(BW'($urandom_range(0, 150)), $urandom_range(1, 150), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
